hazard_unit: RTL
================

# hazard_unit

Pipeline hazard controller for the 5-stage core; it produces the stall and flush controls for the PC, IF/ID and ID/EX pipeline registers. It covers load-use interlock, taken-branch flush, multi-cycle (mul/div) EX occupancy with a watchdog, and EX operand forwarding selects. It also keeps saturating stall and flush event counters for performance debug.

## Interface
- MD_MAX_CYCLES, 64, watchdog limit for cycles spent in MD_WAIT.
- CNT_W, 32, width of the statistics counters.

- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1/rs2
- ex_rs1, ex_rs2  in  5 each  source registers of the instruction in EX
- ex_rd  in  5  destination of the EX instruction
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch or jump this cycle
- ex_md_start  in  1  EX holds a multi-cycle op, first EX cycle only
- md_done  in  1  multi-cycle unit result valid this cycle
- mem_rd, wb_rd  in  5 each  destinations in MEM and WB
- mem_reg_write, wb_reg_write  in  1 each  MEM/WB instruction writes the register file
- pc_stall, if_id_stall, id_ex_stall  out  1 each  hold the register
- if_id_flush, id_ex_flush  out  1 each  clear the register to a bubble at the next edge
- ex_mem_bubble  out  1  EX/MEM captures a bubble this cycle
- fwd_a, fwd_b  out  2 each  EX operand select: 00 register file, 10 MEM, 01 WB
- md_timeout  out  1  sticky watchdog error
- stall_cycles, flush_count  out  CNT_W each  saturating statistics

## Operation
- FSM states: RUN and MD_WAIT. Reset state is RUN.
- Priority in RUN, highest first:
  - Branch: ex_branch_taken → if_id_flush=1, id_ex_flush=1. Load-use is suppressed because the ID instruction is squashed.
  - Multi-cycle: ex_md_start && !md_done → pc_stall, if_id_stall, id_ex_stall, ex_mem_bubble all 1. Next state is MD_WAIT. ex_md_start && md_done in the same cycle → no stall, stay in RUN.
  - Load-use: ex_mem_read && ex_rd≠0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)) → pc_stall=1, if_id_stall=1, id_ex_flush=1 (bubble). This lasts exactly one cycle; the bubble clears ex_mem_read.
- MD_WAIT:
  - While !md_done: pc_stall, if_id_stall, id_ex_stall and ex_mem_bubble are all 1; flush outputs are 0.
  - On md_done: all stalls drop in the same cycle and the next state is RUN.
  - Watchdog counter: cleared on MD_WAIT entry, +1 per MD_WAIT cycle. When it reaches MD_MAX_CYCLES−1 without md_done, md_timeout is set (sticky until rst), stalls release that cycle, and the next state is RUN.
  - ex_branch_taken and ex_md_start are ignored in MD_WAIT, since EX is occupied.
- Forwarding (pure combinational, independent of FSM):
  - fwd_a=10 if mem_reg_write && mem_rd≠0 && mem_rd==ex_rs1.
  - Otherwise fwd_a=01 if wb_reg_write && wb_rd≠0 && wb_rd==ex_rs1.
  - Otherwise fwd_a=00.
  - fwd_b uses the same rules with ex_rs2. MEM wins over WB.
- Counters:
  - stall_cycles +1 on every clock edge where pc_stall=1.
  - flush_count +1 on every edge where if_id_flush=1.
  - Both saturate at all-ones.

## Timing
- Stall, flush, bubble and fwd outputs are combinational from state and the current inputs, with zero latency. Registers consume them at the next posedge.
- State, watchdog, md_timeout and counters are registered.
- Reset values:
  - State RUN, watchdog 0, md_timeout 0, both counters 0.
  - With all inputs 0, every stall, flush, bubble and fwd output is 0.
- rst asserted mid-MD_WAIT returns the block to RUN immediately. Stalls drop while rst is high because the state is RUN and the inputs are expected low.
- A minimum multi-cycle op, with md_done on the cycle after ex_md_start, costs 1 stall cycle.

## Structure
- Shared package hazard_pkg holds:
  - the state enum {RUN, MD_WAIT}
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
- Sub-module forward_unit holds the combinational fwd_a/fwd_b logic. It is instantiated once; the FSM, watchdog and counters live in hazard_unit.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 → for one cycle pc_stall=if_id_stall=id_ex_flush=1. Next cycle with ex_mem_read=0, all are 0 and stall_cycles=1.
- Branch and load-use in the same cycle: ex_branch_taken=1 plus a load-use match → if_id_flush=id_ex_flush=1, pc_stall=0, flush_count=1.
- Multi-cycle op: ex_md_start=1, md_done after 4 cycles → stalls high 4 cycles then low, state back to RUN, stall_cycles=4.
- Watchdog: MD_MAX_CYCLES=8, ex_md_start=1, md_done never asserted → 8 stall cycles, then md_timeout=1 and stalls low. md_timeout stays 1 until rst.
- Forwarding: ex_rs1=3, mem_rd=3, wb_rd=3, both writes=1 → fwd_a=10. With mem_reg_write=0 → fwd_a=01. With ex_rs1=0 and both writes=1 → fwd_a=00.
- Reset mid-MD_WAIT and counter saturation: rst during MD_WAIT → RUN and counters 0. With CNT_W=4 and 20 stall cycles → stall_cycles=15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and forwarding-select encodings for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_unit_forward_unit.sv
// EX operand forwarding selects; the younger MEM result wins over WB.
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] mem_rd,
  input  logic [4:0] wb_rd,
  input  logic       mem_reg_write,
  input  logic       wb_reg_write,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] m_rd, input logic m_we,
                                         input logic [4:0] w_rd, input logic w_we);
    if (m_we && (m_rd != 5'd0) && (m_rd == rs))
      return FWD_MEM;
    else if (w_we && (w_rd != 5'd0) && (w_rd == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    fwd_b = fwd_sel(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
  end

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush controller: load-use interlock, branch flush, multi-cycle EX wait
// with watchdog, plus saturating stall/flush event counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MD_MAX_CYCLES = 64,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             ex_md_start,
  input  logic             md_done,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             mem_reg_write,
  input  logic             wb_reg_write,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WD_W = (MD_MAX_CYCLES > 2) ? $clog2(MD_MAX_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_MAX_CYCLES - 1);

  state_t          state, state_nxt;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expire;
  logic            load_use;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_ex_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    wd_expire     = 1'b0;
    state_nxt     = state;
    case (state)
      RUN: begin
        if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (ex_md_start && !md_done) begin
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          id_ex_stall   = 1'b1;
          ex_mem_bubble = 1'b1;
          state_nxt     = MD_WAIT;
        end else if (load_use) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end
      end
      MD_WAIT: begin
        // Branch and md_start inputs are ignored here: EX still holds the op.
        if (md_done) begin
          state_nxt = RUN;
        end else if (wd_cnt == WD_LAST) begin
          wd_expire = 1'b1;
          state_nxt = RUN;
        end else begin
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          id_ex_stall   = 1'b1;
          ex_mem_bubble = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      wd_cnt       <= '0;
      md_timeout   <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state      <= state_nxt;
      wd_cnt     <= (state == MD_WAIT) ? wd_cnt + WD_W'(1) : '0;
      md_timeout <= md_timeout | wd_expire;
      if (pc_stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (if_id_flush && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

  forward_unit u_forward_unit (
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .mem_rd        (mem_rd),
    .wb_rd         (wb_rd),
    .mem_reg_write (mem_reg_write),
    .wb_reg_write  (wb_reg_write),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b)
  );

endmodule
